// File: rtl/gate_scheduler_if.sv
// Bundle of measurement-control signals between the gate scheduler and the
// count chain / display side.
//
// Strobe protocol: C_Clear, C_Enable and C_Store are level-per-cycle strobes
// driven from registers; at most one of them is high in any cycle. The count
// chain treats C_Enable as a gate (count every cycle it is high), C_Clear as
// a synchronous clear and C_Store as a one-cycle latch pulse. range_change
// is a one-cycle pulse and never coincides with C_Store. OF and BCD3 are
// level inputs; BCD3 is only meaningful after the gate has closed.
interface gate_scheduler_if;
    logic       Run;
    logic       Switch;
    logic [1:0] Select;
    logic       OF;
    logic [3:0] BCD3;
    logic       C_Clear;
    logic       C_Enable;
    logic       C_Store;
    logic [1:0] F_sel;
    logic       range_change;
    logic [1:0] Status_Value;

    // Scheduler side.
    modport master (
        input  Run, Switch, Select, OF, BCD3,
        output C_Clear, C_Enable, C_Store, F_sel, range_change, Status_Value
    );

    // Count chain / environment side.
    modport slave (
        output Run, Switch, Select, OF, BCD3,
        input  C_Clear, C_Enable, C_Store, F_sel, range_change, Status_Value
    );
endinterface

// File: rtl/gate_scheduler.sv
// Frequency-counter gate scheduler: clears the count chain, opens a gate whose
// length follows the active range, evaluates overflow / under-range for
// auto-ranging, then latches the result and holds it for display.
module gate_scheduler #(
    parameter int CLK_PER_MS = 50000,
    parameter int HOLD_MS    = 250
) (
    input  logic              CLK_50,
    input  logic              nRST,
    gate_scheduler_if.master  bus,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        GATE  = 3'd2,
        EVAL  = 3'd3,
        STORE = 3'd4,
        HOLD  = 3'd5
    } state_t;

    // Millisecond counter must reach the longest period in ms (1000 ms gate
    // or the hold time, whichever is larger) without wrapping.
    localparam int MAX_MS = (HOLD_MS > 1000) ? HOLD_MS : 1000;
    localparam int MS_W   = $clog2(MAX_MS + 1);
    localparam int PRE_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
    localparam logic [MS_W-1:0]  GATE0_END = MS_W'(999);
    localparam logic [MS_W-1:0]  GATE1_END = MS_W'(99);
    localparam logic [MS_W-1:0]  GATE2_END = MS_W'(9);
    localparam logic [MS_W-1:0]  GATE3_END = MS_W'(0);
    localparam logic [MS_W-1:0]  HOLD_END  = MS_W'(HOLD_MS - 1);

    state_t            state;
    state_t            state_nx;
    logic [PRE_W-1:0]  pre_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [MS_W-1:0]   last_ms;
    logic              period_done;
    logic              of_seen;
    logic              sw_mode;
    logic              up_range;
    logic              down_range;
    logic [1:0]        f_sel;
    logic [1:0]        f_sel_nx;
    logic              rc_nx;
    logic              c_clear;
    logic              c_enable;
    logic              c_store;
    logic              range_change;
    logic [1:0]        status_value;

    assign bus.C_Clear      = c_clear;
    assign bus.C_Enable     = c_enable;
    assign bus.C_Store      = c_store;
    assign bus.F_sel        = f_sel;
    assign bus.range_change = range_change;
    assign bus.Status_Value = status_value;
    assign dbg_state        = state;

    // Phase code reported for a given state.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            CLEAR, EVAL: phase_of = 2'd1;
            GATE:        phase_of = 2'd2;
            STORE, HOLD: phase_of = 2'd3;
            default:     phase_of = 2'd0;
        endcase
    endfunction

    // Last millisecond index of the current timed period (gate or hold).
    always_comb begin
        last_ms = HOLD_END;
        if (state == GATE) begin
            case (f_sel)
                2'd0:    last_ms = GATE0_END;
                2'd1:    last_ms = GATE1_END;
                2'd2:    last_ms = GATE2_END;
                default: last_ms = GATE3_END;
            endcase
        end
        period_done = (pre_cnt == PRE_LAST) && (ms_cnt == last_ms);
    end

    // Auto-range decisions, using the mode captured in CLEAR.
    always_comb begin
        up_range   = !sw_mode && of_seen && (f_sel != 2'd3);
        down_range = !sw_mode && !of_seen && (bus.BCD3 == 4'd0) && (f_sel != 2'd0);
    end

    // Next-state, next range code and range-change pulse.
    always_comb begin
        state_nx = state;
        f_sel_nx = f_sel;
        rc_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Run) state_nx = CLEAR;
            end
            CLEAR: begin
                if (bus.Switch) f_sel_nx = bus.Select;
                state_nx = GATE;
            end
            GATE: begin
                if (period_done) state_nx = EVAL;
            end
            EVAL: begin
                // A range change discards this measurement and restarts.
                if (up_range) begin
                    f_sel_nx = f_sel + 2'd1;
                    rc_nx    = 1'b1;
                    state_nx = CLEAR;
                end else if (down_range) begin
                    f_sel_nx = f_sel - 2'd1;
                    rc_nx    = 1'b1;
                    state_nx = CLEAR;
                end else begin
                    state_nx = STORE;
                end
            end
            STORE: begin
                state_nx = HOLD;
            end
            HOLD: begin
                // Run is only consulted here, so dropping it never aborts a cycle.
                if (period_done) state_nx = bus.Run ? CLEAR : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    // Registered strobes and phase outputs, decoded from the next state.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            c_clear      <= 1'b0;
            c_enable     <= 1'b0;
            c_store      <= 1'b0;
            range_change <= 1'b0;
            f_sel        <= 2'd0;
            status_value <= 2'd0;
        end else begin
            c_clear      <= (state_nx == CLEAR);
            c_enable     <= (state_nx == GATE);
            c_store      <= (state_nx == STORE);
            range_change <= rc_nx;
            f_sel        <= f_sel_nx;
            status_value <= phase_of(state_nx);
        end
    end

    // Range mode capture and overflow latch.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            sw_mode <= 1'b0;
            of_seen <= 1'b0;
        end else if (state == CLEAR) begin
            sw_mode <= bus.Switch;
            of_seen <= 1'b0;
        end else if (state == GATE && bus.OF) begin
            of_seen <= 1'b1;
        end
    end

    // ms prescaler and ms counter; held at zero outside GATE and HOLD so both
    // start from zero on entry to either timed phase.
    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if ((state != GATE && state != HOLD) || period_done) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            ms_cnt  <= ms_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_scheduler.sv
// Directed bench for gate_scheduler with CLK_PER_MS=10, HOLD_MS=2.
module tb_gate_scheduler;

    localparam int CPM  = 10;
    localparam int HMS  = 2;
    localparam int BUDGET = 20000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_GATE  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic       clk;
    logic       n_rst;
    logic [2:0] dbg_state;
    int         n_assert;
    int         n_fail;
    int         n;
    int         n2;

    gate_scheduler_if bus ();

    gate_scheduler #(.CLK_PER_MS(CPM), .HOLD_MS(HMS)) dut (
        .CLK_50    (clk),
        .nRST      (n_rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive C_Enable cycles starting at the current (gate) sample;
    // OF is driven high for the one cycle following gate cycle of_at.
    task automatic run_gate(input int of_at, output int cnt);
        cnt = 1;
        while (cnt <= BUDGET) begin
            bus.OF = (cnt == of_at);
            tick();
            if (bus.C_Enable) cnt++;
            else break;
        end
        bus.OF = 1'b0;
    endtask

    // Counts HOLD cycles starting at the current (hold) sample.
    task automatic count_hold(output int cnt);
        cnt = 0;
        while (dbg_state == S_HOLD && cnt <= BUDGET) begin
            cnt++;
            tick();
        end
    endtask

    // From an EVAL sample: expect a discarded measurement and a restart.
    task automatic eval_restart(input string tag, input logic [1:0] fsel_exp);
        chk({tag, "_eval_phase"}, bus.Status_Value, 2'd1);
        chk({tag, "_eval_nostore"}, bus.C_Store, 1'b0);
        tick();
        chk({tag, "_rc_pulse"}, bus.range_change, 1'b1);
        chk({tag, "_rc_fsel"}, bus.F_sel, fsel_exp);
        chk({tag, "_rc_clear"}, bus.C_Clear, 1'b1);
        chk({tag, "_rc_nostore"}, bus.C_Store, 1'b0);
        tick();
        chk({tag, "_rc_done"}, bus.range_change, 1'b0);
        chk({tag, "_regate"}, bus.C_Enable, 1'b1);
    endtask

    // From an EVAL sample: expect store then a full hold.
    task automatic eval_store(input string tag, input logic [1:0] fsel_exp);
        int h;
        chk({tag, "_eval_phase"}, bus.Status_Value, 2'd1);
        tick();
        chk({tag, "_store"}, bus.C_Store, 1'b1);
        chk({tag, "_store_rc"}, bus.range_change, 1'b0);
        chk({tag, "_store_fsel"}, bus.F_sel, fsel_exp);
        chk({tag, "_store_phase"}, bus.Status_Value, 2'd3);
        tick();
        chk({tag, "_hold_nostore"}, bus.C_Store, 1'b0);
        count_hold(h);
        chk({tag, "_hold_len"}, h, HMS * CPM);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        bus.Run    = 1'b0;
        bus.Switch = 1'b0;
        bus.Select = 2'd0;
        bus.OF     = 1'b0;
        bus.BCD3   = 4'd0;
        repeat (3) tick();

        // Reset state.
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_clear", bus.C_Clear, 1'b0);
        chk("rst_enable", bus.C_Enable, 1'b0);
        chk("rst_store", bus.C_Store, 1'b0);
        chk("rst_rc", bus.range_change, 1'b0);
        chk("rst_phase", bus.Status_Value, 2'd0);
        chk("rst_fsel", bus.F_sel, 2'd0);
        n_rst = 1'b1;
        tick();
        tick();
        chk("idle_norun", dbg_state, S_IDLE);
        chk("idle_noclear", bus.C_Clear, 1'b0);

        // Manual range 3.
        bus.Switch = 1'b1;
        bus.Select = 2'd3;
        bus.Run    = 1'b1;
        tick();
        chk("m_clear", bus.C_Clear, 1'b1);
        chk("m_clear_phase", bus.Status_Value, 2'd1);
        chk("m_clear_noen", bus.C_Enable, 1'b0);
        tick();
        chk("m_gate_en", bus.C_Enable, 1'b1);
        chk("m_gate_fsel", bus.F_sel, 2'd3);
        chk("m_gate_phase", bus.Status_Value, 2'd2);
        chk("m_gate_noclear", bus.C_Clear, 1'b0);
        bus.Select = 2'd2;   // must not apply until the next CLEAR
        run_gate(-1, n);
        chk("m_gate_len", n, 10);
        chk("m_eval_fsel", bus.F_sel, 2'd3);
        chk("m_eval_noen", bus.C_Enable, 1'b0);
        eval_store("m", 2'd3);
        chk("m_reclear", bus.C_Clear, 1'b1);
        tick();
        chk("m2_gate_en", bus.C_Enable, 1'b1);
        chk("m2_gate_fsel", bus.F_sel, 2'd2);

        // Asynchronous reset mid-gate.
        repeat (30) tick();
        chk("m2_still_gate", bus.C_Enable, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("ar_enable", bus.C_Enable, 1'b0);
        chk("ar_fsel", bus.F_sel, 2'd0);
        chk("ar_store", bus.C_Store, 1'b0);
        chk("ar_phase", bus.Status_Value, 2'd0);
        chk("ar_state", dbg_state, S_IDLE);
        bus.Switch = 1'b0;
        bus.Run    = 1'b1;
        #2;
        n_rst = 1'b1;
        tick();
        chk("ar_first_clear", bus.C_Clear, 1'b1);
        chk("ar_clear_fsel", bus.F_sel, 2'd0);
        tick();

        // Auto: overflow at range 0 moves to range 1.
        run_gate(5000, n);
        chk("a0_gate_len", n, 10000);
        eval_restart("a0_of", 2'd1);
        // Overflow at range 1 moves to range 2.
        run_gate(500, n);
        chk("a1_gate_len", n, 1000);
        eval_restart("a1_of", 2'd2);
        // Under-range at range 2 moves back to range 1.
        run_gate(-1, n);
        chk("a2_gate_len", n, 100);
        eval_restart("a2_ur", 2'd1);
        // Under-range at range 1 moves to range 0.
        run_gate(-1, n);
        chk("a1b_gate_len", n, 1000);
        eval_restart("a1_ur", 2'd0);
        // Under-range at range 0 is a limit: store with no change.
        run_gate(-1, n);
        chk("a0b_gate_len", n, 10000);
        bus.Switch = 1'b1;
        bus.Select = 2'd3;
        eval_store("a0_lim", 2'd0);
        chk("a_reclear", bus.C_Clear, 1'b1);
        tick();

        // Manual range 3 with Run dropped mid-gate.
        chk("r_gate_fsel", bus.F_sel, 2'd3);
        repeat (5) tick();
        bus.Run = 1'b0;
        run_gate(-1, n2);
        chk("r_gate_len", 5 + n2, 10);
        eval_store("r", 2'd3);
        chk("r_idle", dbg_state, S_IDLE);
        chk("r_idle_clear", bus.C_Clear, 1'b0);
        chk("r_idle_enable", bus.C_Enable, 1'b0);
        chk("r_idle_store", bus.C_Store, 1'b0);
        chk("r_idle_phase", bus.Status_Value, 2'd0);
        repeat (3) tick();
        chk("r_idle_stays", dbg_state, S_IDLE);
        chk("r_idle_noclear", bus.C_Clear, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_scheduler.md
GATE_SCHEDULER -- requirements
Module: gate_scheduler

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, SHALL be the number of CLK_50 cycles per millisecond.
REQ-002 Parameter HOLD_MS, default 250, SHALL be the result display hold time in ms.
REQ-003 CLK_50  in  1  SHALL be the system clock; all state changes on its rising edge.
REQ-004 nRST  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Run  in  1  SHALL be continuous-measurement enable; 1 = repeat cycles, 0 = stop after the current cycle.
REQ-006 Switch  in  1  SHALL select the range mode; 1 = manual range from Select, 0 = auto-range.
REQ-007 Select  in  2  SHALL be the manual range code.
REQ-008 OF  in  1  SHALL be the count-chain overflow flag (count above 9999).
REQ-009 BCD3  in  4  SHALL be the most significant count digit, valid after the gate closes.
REQ-010 C_Clear  out  1  SHALL be the counter clear strobe.
REQ-011 C_Enable  out  1  SHALL be the gate (count enable).
REQ-012 C_Store  out  1  SHALL be the latch strobe for the display.
REQ-013 F_sel  out  2  SHALL be the active range code.
REQ-014 range_change  out  1  SHALL pulse when auto-range alters F_sel.
REQ-015 Status_Value  out  2  SHALL encode the phase: 0 idle, 1 clear/eval, 2 gate, 3 store/hold.

Function
REQ-016 The gate length SHALL follow F_sel: 0 -> 1000 ms, 1 -> 100 ms, 2 -> 10 ms, 3 -> 1 ms, in units of CLK_PER_MS cycles.
REQ-017 States SHALL be IDLE, CLEAR, GATE, EVAL, STORE and HOLD.
REQ-018 IDLE SHALL go to CLEAR on the first edge with Run=1; otherwise it SHALL remain in IDLE.
REQ-019 CLEAR SHALL last 1 cycle with C_Clear=1.
- In CLEAR, if Switch=1, F_sel SHALL load Select.
- CLEAR SHALL clear the overflow latch of_seen.
REQ-020 GATE SHALL hold C_Enable=1 for exactly gate_ms*CLK_PER_MS consecutive cycles.
- The gate length SHALL come from the F_sel value at GATE entry.
REQ-021 of_seen SHALL set on any GATE cycle with OF=1.
REQ-022 EVAL SHALL last 1 cycle and SHALL use Switch sampled in CLEAR.
- Auto mode, of_seen=1, F_sel<3: F_sel SHALL increment (shorter gate).
- Auto mode, of_seen=0, BCD3=0, F_sel>0: F_sel SHALL decrement (longer gate).
- Any F_sel change in EVAL SHALL pulse range_change for 1 cycle, skip STORE and HOLD, and go to CLEAR; the measurement is discarded.
- Manual mode or no change: EVAL SHALL go to STORE.
REQ-023 At a range limit (overflow at F_sel=3, or under-range at F_sel=0), EVAL SHALL store normally with no change.
REQ-024 STORE SHALL last 1 cycle with C_Store=1.
REQ-025 HOLD SHALL last HOLD_MS*CLK_PER_MS cycles.
- It SHALL then go to CLEAR if Run=1, else to IDLE.
REQ-026 Run falling in any non-IDLE state SHALL NOT abort the cycle; it takes effect only at the end of HOLD.
- After a range-change restart, Run SHALL be ignored until the next HOLD completes.
REQ-027 Switch or Select changes outside CLEAR SHALL have no effect until the next CLEAR.
REQ-028 C_Clear, C_Enable and C_Store SHALL be registered and mutually exclusive; range_change SHALL never coincide with C_Store.
REQ-029 The ms prescaler and gate counter SHALL be wide enough for 1000*CLK_PER_MS cycles without wrap.
- Both SHALL restart at zero on GATE and HOLD entry.

Reset
REQ-030 nRST=0 SHALL immediately force the following, regardless of the clock:
- state IDLE;
- C_Clear, C_Enable, C_Store, range_change = 0;
- Status_Value = 0, F_sel = 0;
- of_seen and all counters = 0.
REQ-031 Reset asserted mid-GATE SHALL drop C_Enable in the same cycle with no C_Store.
REQ-032 After nRST rises, the first CLEAR SHALL occur on the first edge with Run=1.

Verification (CLK_PER_MS=10, HOLD_MS=2)
REQ-033 Manual range: Switch=1, Select=3, Run=1, OF=0 -> expected response:
- C_Clear for 1 cycle, then C_Enable for 10 cycles, EVAL 1 cycle, C_Store 1 cycle, hold 20 cycles, repeat;
- F_sel=3 throughout.
REQ-034 Auto overflow: Switch=0, F_sel=0, OF pulsed mid-gate -> expected response:
- after 10000 gate cycles, range_change pulse and F_sel=1;
- no C_Store;
- next C_Enable run of 1000 cycles.
REQ-035 Auto under-range: F_sel=2, BCD3=0, OF=0 -> range_change, F_sel=1, no C_Store. F_sel=0, BCD3=0 -> C_Store, F_sel stays 0.
REQ-036 Run dropped mid-GATE at F_sel=3 -> gate completes at 10 cycles, C_Store, 20-cycle hold, then IDLE with all strobes 0.
REQ-037 nRST pulsed low mid-GATE -> C_Enable=0 and F_sel=0 immediately; on release with Run=1, C_Clear on the first edge.
